secure_tx_channel: RTL and testbench

SECURE_TX_CHANNEL -- requirements
Module: secure_tx_channel

---
 rtl/secure_tx_channel.sv | 134 +++++++++++++
 tb/tb_secure_tx_channel.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secure_tx_channel.sv
// secure_tx_channel
//   Keyed transmit channel. Plaintext words are XORed with a keystream that is
//   derived from the loaded key and a per-word sequence counter. The resulting
//   ciphertext is queued in a small in-order FIFO for the downstream consumer.
//   The key, the keystream and the plaintext never reach an output port.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   key_load   one-cycle request to latch key_in
//   key_in     key value, sampled only when key_load is accepted
//   zeroize    one-cycle request to clear the key and flush the FIFO
//   in_valid   plaintext word offered
//   in_ready   channel can take a plaintext word this cycle
//   in_data    plaintext word
//   out_valid  ciphertext word available at the FIFO head
//   out_ready  consumer takes the head word this cycle
//   out_data   ciphertext word (all zeros while the FIFO is empty)
//   keyed      a key is loaded
//   key_err    one-cycle pulse after a rejected key_load
module secure_tx_channel #(
   parameter int DATA_W     = 32,
   parameter int KEY_W      = 128,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              key_load,
   input  logic [KEY_W-1:0]  key_in,
   input  logic              zeroize,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              keyed,
   output logic              key_err
);

   localparam int NSLICE = KEY_W / DATA_W;
   localparam int SL_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);

   typedef enum logic {NOKEY, ACTIVE} state_t;

   state_t              state_q, state_d;
   logic [KEY_W-1:0]    key_q;
   logic [DATA_W-1:0]   seq_q;
   logic [PTR_W:0]      wr_ptr_q, rd_ptr_q;
   logic                key_err_q;
   logic [DATA_W-1:0]   mem [FIFO_DEPTH];

   logic                fifo_empty, fifo_full;
   logic                push, pop;
   logic                key_accept, key_reject;
   logic [DATA_W-1:0]   ct;

   // Key slice selected by the low bits of seq, mixed with seq itself.
   function automatic logic [DATA_W-1:0] keystream(input logic [KEY_W-1:0]  key,
                                                    input logic [DATA_W-1:0] seq);
      logic [SL_W-1:0]   idx;
      logic [DATA_W-1:0] slice;
      idx   = (NSLICE > 1) ? seq[SL_W-1:0] : '0;
      slice = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (idx == SL_W'(i)) slice = key[i*DATA_W +: DATA_W];
      end
      return slice ^ seq;
   endfunction

   // The extra pointer bit separates full (MSBs differ) from empty (equal).
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;
   assign ct   = in_data ^ keystream(key_q, seq_q);

   // A rekey is only allowed when no ciphertext under the old key is pending.
   assign key_accept = key_load && !zeroize && ((state_q == NOKEY) || fifo_empty);
   assign key_reject = key_load && !zeroize && (state_q == ACTIVE) && !fifo_empty;

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = !fifo_empty;
      // Empty FIFO presents zeros so stale or flushed words never leak out.
      out_data  = fifo_empty ? '0 : mem[rd_ptr_q[PTR_W-1:0]];
      keyed     = (state_q == ACTIVE);
      key_err   = key_err_q;
      if (zeroize)         state_d = NOKEY;
      else if (key_accept) state_d = ACTIVE;
      if ((state_q == ACTIVE) && !fifo_full && !zeroize) in_ready = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= NOKEY;
         key_q     <= '0;
         seq_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         key_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         key_err_q <= key_reject;
         if (zeroize) begin
            key_q    <= '0;
            seq_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            // A word pushed on the rekey edge was encrypted with the old key;
            // the new key always starts from seq 0.
            if (key_accept) begin
               key_q <= key_in;
               seq_q <= '0;
            end else if (push) begin
               seq_q <= seq_q + 1'b1;
            end
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Storage needs no reset: occupancy is governed by the pointers alone.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q[PTR_W-1:0]] <= ct;
   end

endmodule

// File: tb/tb_secure_tx_channel.sv
module tb_secure_tx_channel;
   localparam int DW = 32;
   localparam int KW = 128;
   localparam logic [KW-1:0] K  = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [KW-1:0] K2 = 128'hDEADBEEFCAFEF00D0BADC0DE13579BDF;

   logic          clk = 1'b0;
   logic          reset = 1'b0, key_load = 1'b0, zeroize = 1'b0;
   logic          in_valid = 1'b0, out_ready = 1'b0;
   logic [KW-1:0] key_in = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, out_valid, keyed, key_err;
   logic [DW-1:0] out_data;

   // Narrow instance so the sequence counter wraps within a few pushes.
   logic          s_reset = 1'b0, s_key_load = 1'b0, s_zeroize = 1'b0;
   logic          s_in_valid = 1'b0, s_out_ready = 1'b0;
   logic [15:0]   s_key_in = '0;
   logic [3:0]    s_in_data = '0;
   logic          s_in_ready, s_out_valid, s_keyed, s_key_err;
   logic [3:0]    s_out_data;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] exp_q[$];
   logic [3:0]    sexp_q[$];
   logic [KW-1:0] key_m;
   logic [DW-1:0] seq_m;

   always #5 clk = ~clk;

   secure_tx_channel dut (
      .clk(clk), .reset(reset), .key_load(key_load), .key_in(key_in),
      .zeroize(zeroize), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .keyed(keyed), .key_err(key_err)
   );

   secure_tx_channel #(.DATA_W(4), .KEY_W(16), .FIFO_DEPTH(2)) dut_s (
      .clk(clk), .reset(s_reset), .key_load(s_key_load), .key_in(s_key_in),
      .zeroize(s_zeroize), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_data(s_out_data), .keyed(s_keyed), .key_err(s_key_err)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] ks_m(input logic [KW-1:0] k, input logic [DW-1:0] s);
      int idx;
      idx = int'(s[1:0]);
      return k[idx*DW +: DW] ^ s;
   endfunction

   // Scoreboard monitors: compare whenever the DUT hands over a word.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_out: got %h, required no output", out_data);
         end else begin
            check("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!s_reset && s_out_valid && s_out_ready) begin
         if (sexp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_s_out: got %h, required no output", s_out_data);
         end else begin
            check("s_out_data", s_out_data, sexp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] e);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (!in_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL push_timeout: in_ready=%b, required 1", in_ready);
      end else begin
         @(posedge clk);
         exp_q.push_back(e);
         seq_m++;
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_m(input logic [DW-1:0] d);
      send(d, d ^ ks_m(key_m, seq_m));
   endtask

   task automatic s_send(input logic [3:0] d, input logic [3:0] e);
      int n = 0;
      s_in_valid = 1'b1;
      s_in_data  = d;
      while (!s_in_ready && n < 200) begin @(negedge clk); n++; end
      if (!s_in_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL s_push_timeout: s_in_ready=%b, required 1", s_in_ready);
      end else begin
         @(posedge clk);
         sexp_q.push_back(e);
      end
      #1;
      s_in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin @(negedge clk); n++; end
      check("drain_done", {exp_q.size() == 0, out_valid}, 2'b10);
   endtask

   task automatic load_key(input logic [KW-1:0] k);
      @(negedge clk);
      key_load = 1'b1;
      key_in   = k;
      @(posedge clk);
      #1;
      key_load = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] d4, e4;
      #1;
      reset = 1'b1;
      s_reset = 1'b1;
      #1;
      check("reset_flags", {in_ready, out_valid, keyed, key_err}, 4'b0000);
      check("reset_out_data", out_data, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      s_reset = 1'b0;

      // No key: channel must refuse data and stay unkeyed.
      in_valid = 1'b1;
      in_data  = 32'h00001234;
      key_in   = K;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("nokey_idle", {in_ready, out_valid, keyed}, 3'b000);
      end
      in_valid = 1'b0;

      load_key(K);
      check("keyed_after_load", keyed, 1'b1);
      check("no_err_first_load", key_err, 1'b0);
      key_m = K;
      seq_m = '0;

      // Hand-computed ciphertext for K, seq 0 and 1.
      out_ready = 1'b1;
      send(32'h00000000, 32'h76543210);
      check("latency_valid", out_valid, 1'b1);
      send(32'hFFFFFFFF, 32'h01234566);
      drain();

      // Fill to capacity with the consumer stalled.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_m(32'hA0A00000 + 32'(i));
      check("full_in_ready", in_ready, 1'b0);
      fork
         send_m(32'h5555AAAA);
         begin
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check("stall_hold_data", out_data, exp_q[0]);
               check("stall_in_ready", in_ready, 1'b0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Rekey with words pending is rejected; old key stays in use.
      out_ready = 1'b0;
      send_m(32'h11112222);
      send_m(32'h33334444);
      load_key(K2);
      check("key_err_pulse", key_err, 1'b1);
      @(posedge clk);
      #1;
      check("key_err_one_cycle", key_err, 1'b0);
      check("keyed_after_reject", keyed, 1'b1);
      drain();
      send_m(32'hCAFE0001);
      drain();
      load_key(K2);
      check("rekey_no_err", key_err, 1'b0);
      key_m = K2;
      seq_m = '0;
      send_m(32'h00000000);
      drain();

      // zeroize beats a simultaneous key_load and push.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_m(32'h0BAD0000 + 32'(i));
      @(negedge clk);
      zeroize  = 1'b1;
      key_load = 1'b1;
      key_in   = K;
      in_valid = 1'b1;
      in_data  = 32'h12345678;
      #1;
      check("zeroize_blocks_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      zeroize  = 1'b0;
      key_load = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      check("zeroize_flags", {out_valid, keyed, key_err}, 3'b000);
      check("zeroize_out_data", out_data, 0);
      @(posedge clk);
      #1;
      check("zeroize_no_late_err", {keyed, key_err}, 2'b00);
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Asynchronous reset between edges.
      load_key(K);
      key_m = K;
      seq_m = '0;
      out_ready = 1'b0;
      send_m(32'h01010101);
      send_m(32'h02020202);
      @(negedge clk);
      in_valid = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_flags", {in_ready, out_valid, keyed, key_err}, 4'b0000);
      check("async_reset_out_data", out_data, 0);
      exp_q.delete();
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset  = 1'b0;
      key_in = K;
      repeat (3) @(negedge clk);
      check("no_key_after_reset", keyed, 1'b0);

      // Narrow instance: seq wraps from 15 to 0 and returns to slice 0.
      @(negedge clk);
      s_key_load = 1'b1;
      s_key_in   = 16'hA5C3;
      @(posedge clk);
      #1;
      s_key_load  = 1'b0;
      s_out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         if (i < 15) begin
            d4 = 4'(i * 7);
            e4 = d4 ^ s_key_in[(i % 4) * 4 +: 4] ^ 4'(i);
         end else if (i == 15) begin
            d4 = 4'h0;
            e4 = 4'h5;
         end else begin
            d4 = 4'h0;
            e4 = 4'h3;
         end
         s_send(d4, e4);
         check("s_no_x", $isunknown({s_in_ready, s_out_valid, s_out_data, s_keyed, s_key_err}), 1'b0);
      end
      for (int n = 0; n < 50 && (sexp_q.size() != 0 || s_out_valid); n++) @(negedge clk);
      check("s_drain_done", {sexp_q.size() == 0, s_out_valid}, 2'b10);
      check("main_no_x", $isunknown({in_ready, out_valid, out_data, keyed, key_err}), 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
